// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit: shift-add multiply, restoring divide,
// one step per cycle for 32 cycles, with registered results and {N,Z} flags.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  ALUControl,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Result,
    output logic [31:0] ResultHi,
    output logic [1:0]  ALUFlags
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_UMUL = 2'b01,
        OP_SMUL = 2'b10,
        OP_MUL  = 2'b11
    } op_t;

    state_t      state;
    op_t         op;
    logic [4:0]  count;
    logic        negate;
    logic [31:0] operand;
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;

    logic        start_smul;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] sum;
    logic [32:0] shifted;
    logic [31:0] diff;
    logic        borrow;
    logic [31:0] next_hi;
    logic [31:0] next_lo;
    logic [63:0] prod;
    logic [63:0] sprod;
    logic [31:0] fin_lo;
    logic [31:0] fin_hi;
    logic [1:0]  fin_flags;

    // Operand conditioning at the accepting edge: SMUL works on magnitudes.
    always_comb begin
        start_smul = (ALUControl[1:0] == OP_SMUL);
        abs_a      = (start_smul && SrcA[31]) ? -SrcA : SrcA;
        abs_b      = (start_smul && SrcB[31]) ? -SrcB : SrcB;
    end

    // One iteration step. Multiply keeps {acc_hi,acc_lo} as the partial
    // product with the multiplier shifting out of acc_lo; divide keeps the
    // remainder in acc_hi and shifts the dividend/quotient through acc_lo.
    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : 33'd0);
        shifted = {acc_hi, acc_lo[31]};
        borrow  = (shifted < {1'b0, operand});
        diff    = shifted[31:0] - operand;
        if (op == OP_DIV) begin
            next_hi = borrow ? shifted[31:0] : diff;
            next_lo = {acc_lo[30:0], ~borrow};
        end else begin
            next_hi = sum[32:1];
            next_lo = {sum[0], acc_lo[31:1]};
        end
    end

    // Final result selection from the last step, applied at the edge that enters DONE.
    always_comb begin
        prod  = {next_hi, next_lo};
        sprod = negate ? -prod : prod;
        fin_lo    = next_lo;
        fin_hi    = next_hi;
        fin_flags = 2'b00;
        case (op)
            OP_MUL: begin
                fin_lo    = prod[31:0];
                fin_hi    = 32'd0;
                fin_flags = {prod[31], (prod[31:0] == 32'd0)};
            end
            OP_SMUL: begin
                fin_lo    = sprod[31:0];
                fin_hi    = sprod[63:32];
                fin_flags = {sprod[63], (sprod == 64'd0)};
            end
            OP_UMUL: begin
                fin_lo    = prod[31:0];
                fin_hi    = prod[63:32];
                fin_flags = {prod[63], (prod == 64'd0)};
            end
            default: begin
                fin_lo    = next_lo;
                fin_hi    = next_hi;
                fin_flags = {next_lo[31], (next_lo == 32'd0)};
            end
        endcase
    end

    // Control FSM and datapath registers; Start is only honoured in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            op       <= OP_DIV;
            count    <= 5'd0;
            negate   <= 1'b0;
            operand  <= 32'd0;
            acc_hi   <= 32'd0;
            acc_lo   <= 32'd0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Result   <= 32'd0;
            ResultHi <= 32'd0;
            ALUFlags <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (Start && ALUControl[2]) begin
                        state  <= RUN;
                        Busy   <= 1'b1;
                        count  <= 5'd31;
                        op     <= op_t'(ALUControl[1:0]);
                        negate <= start_smul && (SrcA[31] ^ SrcB[31]);
                        acc_hi <= 32'd0;
                        if (ALUControl[1:0] == OP_DIV) begin
                            operand <= SrcB;
                            acc_lo  <= SrcA;
                        end else begin
                            operand <= abs_a;
                            acc_lo  <= abs_b;
                        end
                    end
                end
                RUN: begin
                    acc_hi <= next_hi;
                    acc_lo <= next_lo;
                    if (count == 5'd0) begin
                        state    <= DONE;
                        Busy     <= 1'b0;
                        Done     <= 1'b1;
                        Result   <= fin_lo;
                        ResultHi <= fin_hi;
                        ALUFlags <= fin_flags;
                    end else begin
                        count <= count - 5'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    Done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed and random operations checked against
// a plain-arithmetic reference model, plus Start-ignore and reset scenarios.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [2:0]  ALUControl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;
    logic [31:0] ResultHi;
    logic [1:0]  ALUFlags;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [65:0] last_exp;

    muldiv_unit dut (
        .clk        (clk),
        .reset      (reset),
        .Start      (Start),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .Busy       (Busy),
        .Done       (Done),
        .Result     (Result),
        .ResultHi   (ResultHi),
        .ALUFlags   (ALUFlags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: expected {ResultHi, Result, ALUFlags} from arithmetic.
    function automatic logic [65:0] model(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sp;
        logic [31:0] r;
        logic [31:0] h;
        logic [1:0]  f;
        p = {32'd0, a} * {32'd0, b};
        case (opc)
            3'b111: begin r = p[31:0]; h = 32'd0; end
            3'b101: begin r = p[31:0]; h = p[63:32]; end
            3'b110: begin
                sp = longint'(signed'(a)) * longint'(signed'(b));
                p  = 64'(sp);
                r  = p[31:0];
                h  = p[63:32];
            end
            default: begin
                if (b == 32'd0) begin r = 32'hFFFF_FFFF; h = a; end
                else begin r = a / b; h = a % b; end
            end
        endcase
        if (opc == 3'b110 || opc == 3'b101) f = {h[31], ({h, r} == 64'd0)};
        else                                f = {r[31], (r == 32'd0)};
        return {h, r, f};
    endfunction

    // Issues one operation and follows it to DONE and back to IDLE.
    // lat = edge number (accepting edge = 1) at which Done was seen, 0 on timeout.
    task automatic do_op(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b,
                         input int inject_at, output int lat, output bit busy_ok, output bit idle_ok);
        int edge_n;
        @(negedge clk);
        Start = 1'b1; ALUControl = opc; SrcA = a; SrcB = b;
        @(posedge clk); #1;
        Start = 1'b0; SrcA = $urandom; SrcB = $urandom;
        lat = 0; busy_ok = 1'b1; idle_ok = 1'b0; edge_n = 1;
        while (edge_n < 40) begin
            if (Done) begin lat = edge_n; break; end
            if (!Busy) busy_ok = 1'b0;
            if (edge_n == inject_at) begin
                Start = 1'b1; ALUControl = 3'b100; SrcA = $urandom; SrcB = $urandom_range(1, 9);
            end else begin
                Start = 1'b0;
            end
            @(posedge clk); #1;
            edge_n++;
        end
        Start = 1'b0;
        @(posedge clk); #1;
        idle_ok = !Done && !Busy;
    endtask

    task automatic test_reset();
        reset = 1'b1; Start = 1'b0; ALUControl = 3'b000; SrcA = 32'd0; SrcB = 32'd0;
        #1;
        n_cmp++;
        if ({Busy, Done, Result, ResultHi, ALUFlags} !== 68'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_state got %h expected 0", {Busy, Done, Result, ResultHi, ALUFlags});
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        last_exp = 66'd0;
    endtask

    task automatic run_and_check(input string name, input logic [2:0] opc, input logic [31:0] a,
                                 input logic [31:0] b, input int inject_at);
        int lat; bit busy_ok; bit idle_ok;
        logic [65:0] exp_v;
        exp_v = model(opc, a, b);
        do_op(opc, a, b, inject_at, lat, busy_ok, idle_ok);
        n_cmp++;
        if (lat !== 33) begin
            n_fail++;
            $display("[TB] FAIL %s_latency got %0d expected 33", name, lat);
        end
        n_cmp++;
        if ({ResultHi, Result, ALUFlags} !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL %s_result op=%b a=%h b=%h got hi=%h lo=%h f=%b expected hi=%h lo=%h f=%b",
                     name, opc, a, b, ResultHi, Result, ALUFlags, exp_v[65:34], exp_v[33:2], exp_v[1:0]);
        end
        n_cmp++;
        if ({busy_ok, idle_ok} !== 2'b11) begin
            n_fail++;
            $display("[TB] FAIL %s_handshake got busy_ok=%0b idle_after=%0b expected 1 1", name, busy_ok, idle_ok);
        end
        last_exp = exp_v;
    endtask

    task automatic test_directed();
        run_and_check("mul_7x6",     3'b111, 32'd7,         32'd6,         0);
        run_and_check("umul_max",    3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_and_check("smul_neg3x5", 3'b110, 32'hFFFF_FFFD, 32'd5,         0);
        run_and_check("smul_minmin", 3'b110, 32'h8000_0000, 32'h8000_0000, 0);
        run_and_check("div_100_7",   3'b100, 32'd100,       32'd7,         0);
        run_and_check("div_by_zero", 3'b100, 32'h0000_1234, 32'd0,         0);
        run_and_check("umul_zero",   3'b101, 32'd0,         32'h1234_5678, 0);
    endtask

    task automatic test_invalid_start();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            Start = 1'b1; ALUControl = 3'($urandom_range(0, 3)); SrcA = $urandom; SrcB = $urandom;
            @(posedge clk); #1;
            n_cmp++;
            if ({Busy, Done, ResultHi, Result, ALUFlags} !== {2'b00, last_exp}) begin
                n_fail++;
                $display("[TB] FAIL invalid_start got busy=%b done=%b lo=%h expected idle, lo=%h",
                         Busy, Done, Result, last_exp[33:2]);
            end
        end
        Start = 1'b0;
    endtask

    task automatic test_start_in_run();
        run_and_check("start_in_run", 3'b101, 32'hDEAD_BEEF, 32'h0000_1357, 10);
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if ({ResultHi, Result, ALUFlags} !== last_exp) begin
            n_fail++;
            $display("[TB] FAIL result_hold got lo=%h expected lo=%h", Result, last_exp[33:2]);
        end
    endtask

    task automatic test_reset_midrun();
        bit saw_done;
        @(negedge clk);
        Start = 1'b1; ALUControl = 3'b111; SrcA = 32'd123; SrcB = 32'd456;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (14) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if ({Busy, Done, Result, ResultHi, ALUFlags} !== 68'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_midrun got %h expected 0", {Busy, Done, Result, ResultHi, ALUFlags});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            if (Done || Busy) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL aborted_op_activity got %b expected 0", saw_done);
        end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        run_and_check("mul_3x3_after_reset", 3'b111, 32'd3, 32'd3, 0);
    endtask

    task automatic test_random();
        logic [2:0]  opc;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 30; i++) begin
            opc = {1'b1, 2'($urandom_range(0, 3))};
            a   = $urandom;
            b   = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = $urandom_range(1, 16);
                2: a = {1'b1, 31'($urandom)};
                default: ;
            endcase
            run_and_check("random", opc, a, b, 0);
        end
    endtask

    task automatic test_back_to_back();
        run_and_check("b2b_div", 3'b100, 32'hFFFF_FFFF, 32'd3,         0);
        run_and_check("b2b_smul", 3'b110, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0);
        run_and_check("b2b_mul", 3'b111, 32'h0001_0000, 32'h0001_0000, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_invalid_start();
        test_start_in_run();
        test_reset_midrun();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have one clock `clk`; reset is asynchronous and active-high (`reset`); all state updates on the rising edge of `clk`.
REQ-002 SHALL have ports:
- `clk` input 1: system clock.
- `reset` input 1: async active-high reset.
- `Start` input 1: operation request from control.
- `ALUControl` input 3: op code.
- `SrcA` input 32: multiplicand / dividend.
- `SrcB` input 32: multiplier / divisor.
- `Busy` output 1: iteration in progress.
- `Done` output 1: result valid pulse.
- `Result` output 32: low product / quotient.
- `ResultHi` output 32: high product / remainder.
- `ALUFlags` output 2: {N,Z}.

Function
REQ-003 SHALL decode op codes:
- 3'b111 MUL: low 32 bits of unsigned product; ResultHi = 0.
- 3'b110 SMUL: signed 64-bit product.
- 3'b101 UMUL: unsigned 64-bit product.
- 3'b100 DIV: unsigned quotient in Result, remainder in ResultHi.
REQ-004 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-005 In IDLE, `Start`=1 with ALUControl[2]=1 SHALL be accepted at that edge; state goes to RUN.
REQ-006 SHALL latch operands, op and a 5-bit iteration counter (=31) at the accepting edge.
REQ-007 In IDLE, `Start`=1 with ALUControl[2]=0 SHALL be ignored; state stays IDLE and outputs are unchanged.
REQ-008 RUN SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle, for exactly 32 cycles.
REQ-009 SHALL set state DONE at the 33rd edge counting the accepting edge as edge 1, registering Result, ResultHi and ALUFlags at that same edge.
REQ-010 DONE SHALL last exactly one cycle, then go to IDLE.
REQ-011 `Done`=1 only in DONE.
REQ-012 `Busy`=1 only in RUN.
REQ-013 `Start` in RUN or DONE SHALL be ignored; latched operands are unaffected.
REQ-014 SMUL SHALL multiply operand magnitudes unsigned, then two's-complement negate the 64-bit product when the sign bits differ.
REQ-015 SMUL of 0x80000000*0x80000000 SHALL yield Hi 0x40000000, Lo 0x00000000.
REQ-016 DIV with SrcB=0 SHALL run the full 32 cycles and yield Result 0xFFFFFFFF, ResultHi = SrcA; no error signal.
REQ-017 ALUFlags N SHALL be ResultHi[31] for SMUL/UMUL, else Result[31].
REQ-018 ALUFlags Z SHALL be 1 iff {ResultHi,Result}==0 for SMUL/UMUL, or Result==0 for MUL/DIV.
REQ-019 Result, ResultHi and ALUFlags SHALL hold their value from DONE until the next DONE.
REQ-020 Outputs SHALL be registered (no combinational path from SrcA/SrcB).

Reset
REQ-021 While `reset`=1, the block SHALL immediately force state IDLE, Busy=0, Done=0, Result=0, ResultHi=0, ALUFlags=2'b00 and counter=0, without waiting for a clock edge.
REQ-022 Reset asserted mid-RUN SHALL abort the operation; no Done pulse for that operation.
REQ-023 The first edge after reset release SHALL accept a valid Start.

Verification
REQ-024 MUL: SrcA=7, SrcB=6 -> Done after 33 edges; Result=0x0000002A, ResultHi=0, flags 00.
REQ-025 UMUL: 0xFFFFFFFF*0xFFFFFFFF -> ResultHi=0xFFFFFFFE, Result=0x00000001, N=1, Z=0.
REQ-026 SMUL: 0xFFFFFFFD(-3)*5 -> ResultHi=0xFFFFFFFF, Result=0xFFFFFFF1, N=1.
REQ-027 DIV: 100/7 -> Result=14, ResultHi=2; DIV 0x1234/0 -> Result=0xFFFFFFFF, ResultHi=0x1234.
REQ-028 Start pulsed at RUN cycle 10 with different operands -> ignored; original result produced; Busy stays 1 throughout.
REQ-029 Reset at RUN cycle 15 -> all outputs 0 at once; no Done; new MUL 3*3 after release -> Result=9 after 33 edges.
